lsu_cache_port: RTL and testbench

Load/store-unit front end that drives the request side of the single-line data cache. It accepts one memory operation at a time from the pipeline (load, store, or flush of any size from byte to doubleword) and issues the corresponding `CACHE::cache_cmd_t` request sequence. It holds each request stable until `respcyc`, performs read-modify-write for sub-doubleword stores, and returns sign- or zero-extended load data with a one-cycle completion pulse.

---
 rtl/lsu_cache_port.sv | 123 ++++++++++++
 tb/tb_lsu_cache_port.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lsu_cache_port.sv
// lsu_cache_port: LSU front end issuing READ/WRITE/FLUSH cache requests with RMW for sub-dword stores; LSU_MISALIGN_TRAP_EN traps misaligned ops
package CACHE;
  typedef enum logic [1:0] {IDLE, READ, WRITE, FLUSH} cache_cmd_t;
endpackage

module lsu_cache_port (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         op_kind,
  input  logic [1:0]         op_size,
  input  logic               op_signed,
  input  logic [63:0]        op_addr,
  input  logic [63:0]        op_wdata,
  output logic               done_valid,
  output logic [63:0]        done_data,
  output logic               done_misaligned,
  output CACHE::cache_cmd_t  req_cmd,
  output logic [63:0]        req_addr,
  output logic [63:0]        req_data,
  input  logic               respcyc,
  input  logic [63:0]        resp_data
);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FL, S_DONE} state_t;
  state_t state;
  logic st, sgn, mis, sb;
  logic [1:0] size;
  logic [2:0] lane, op_lo;
  logic [5:0] sh;
  logic [63:0] wdata, a_in, bm, raw, ext, merged;
  always_comb begin
    op_lo = op_size == 2'd0 ? 3'd0 : op_size == 2'd1 ? 3'd1 : op_size == 2'd2 ? 3'd3 : 3'd7;
    mis = |(op_addr[2:0] & op_lo);
    a_in = TRAP ? op_addr : {op_addr[63:3], op_addr[2:0] & ~op_lo};
    bm = size == 2'd0 ? 64'hff : size == 2'd1 ? 64'hffff : size == 2'd2 ? 64'hffff_ffff : '1;
    sh = {lane, 3'b000};
    raw = resp_data >> sh;
    sb = sgn & (size == 2'd0 ? raw[7] : size == 2'd1 ? raw[15] : raw[31]);
    ext = size == 2'd3 ? raw : (raw & bm) | (sb ? ~bm : 64'd0);
    merged = (resp_data & ~(bm << sh)) | ((wdata & bm) << sh);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_ready <= 1'b1;
      done_valid <= 1'b0;
      done_data <= '0;
      done_misaligned <= 1'b0;
      req_cmd <= CACHE::IDLE;
      req_addr <= '0;
      req_data <= '0;
      st <= 1'b0;
      sgn <= 1'b0;
      size <= '0;
      lane <= '0;
      wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (op_valid) begin
          op_ready <= 1'b0;
          st <= op_kind == 2'd1;
          sgn <= op_signed;
          size <= op_size;
          lane <= a_in[2:0];
          wdata <= op_wdata;
          req_addr <= op_kind[1] ? a_in : {a_in[63:3], 3'b000};
          if (TRAP && mis) begin
            state <= S_DONE;
            done_valid <= 1'b1;
            done_data <= '0;
            done_misaligned <= 1'b1;
          end else if (op_kind == 2'd0 || (op_kind == 2'd1 && op_size != 2'd3)) begin
            state <= S_RD;
            req_cmd <= CACHE::READ;
          end else if (op_kind == 2'd1) begin
            state <= S_WR;
            req_cmd <= CACHE::WRITE;
            req_data <= op_wdata;
          end else begin
            state <= S_FL;
            req_cmd <= CACHE::FLUSH;
          end
        end
        S_RD: if (respcyc) begin
          if (st) begin
            state <= S_WR;
            req_cmd <= CACHE::WRITE;
            req_data <= merged;
          end else begin
            state <= S_DONE;
            req_cmd <= CACHE::IDLE;
            done_valid <= 1'b1;
            done_data <= ext;
            done_misaligned <= 1'b0;
          end
        end
        S_WR, S_FL: if (respcyc) begin
          state <= S_DONE;
          req_cmd <= CACHE::IDLE;
          done_valid <= 1'b1;
          done_data <= '0;
          done_misaligned <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
          done_valid <= 1'b0;
          op_ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          req_cmd <= CACHE::IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_cache_port.sv
// tb_lsu_cache_port: randomized scoreboard bench for lsu_cache_port against a byte-addressed reference memory
module tb_lsu_cache_port;
  logic clk = 1'b0, reset = 1'b1, op_valid = 1'b0, op_signed = 1'b0, respcyc = 1'b0;
  logic [1:0] op_kind = '0, op_size = '0;
  logic [63:0] op_addr = '0, op_wdata = '0, resp_data = '0;
  logic op_ready, done_valid, done_misaligned;
  logic [63:0] done_data, req_addr, req_data;
  CACHE::cache_cmd_t req_cmd;
  lsu_cache_port dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
    .op_size(op_size), .op_signed(op_signed), .op_addr(op_addr), .op_wdata(op_wdata),
    .done_valid(done_valid), .done_data(done_data), .done_misaligned(done_misaligned),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data), .respcyc(respcyc), .resp_data(resp_data)
  );
  always #5 clk = ~clk;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef struct {logic [63:0] data; logic mis; int lat;} exp_t;
  exp_t exp_q[$];
  logic [63:0] fl_q[$];
  logic [7:0] ref_mem[logic [63:0]];
  logic [63:0] cmem[logic [60:0]];
  int compared = 0, mismatched = 0, n_done = 0, cyc = 0, t_acc = 0, rd_dly = 0, wr_dly = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && op_valid && op_ready) t_acc = cyc + 1;
      if (done_valid) begin
        n_done++;
        if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("done_data", done_data, e.data);
          chk("done_misaligned", 64'(done_misaligned), 64'(e.mis));
          chk("latency", 64'(cyc - t_acc + 1), 64'(e.lat));
        end
      end
    end
  end
  initial begin
    bit active, ok;
    int cnt;
    CACHE::cache_cmd_t s_cmd;
    logic [63:0] s_addr, s_data;
    active = 0; ok = 1; cnt = 0; s_cmd = CACHE::IDLE; s_addr = '0; s_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0;
        respcyc = 1'b0;
      end else begin
        if (active && respcyc) begin
          chk("req_stable", 64'(ok), 64'd1);
          if (s_cmd == CACHE::WRITE) cmem[s_addr[63:3]] = s_data;
          if (s_cmd == CACHE::FLUSH) begin
            if (fl_q.size() == 0) chk("unexpected_flush", 64'd1, 64'd0);
            else chk("flush_addr", s_addr, fl_q.pop_front());
          end
          active = 0;
        end
        respcyc = 1'b0;
        if (active) ok &= (req_cmd == s_cmd && req_addr == s_addr && req_data == s_data);
        else if (req_cmd != CACHE::IDLE) begin
          active = 1; ok = 1;
          s_cmd = req_cmd; s_addr = req_addr; s_data = req_data;
          cnt = req_cmd == CACHE::WRITE ? wr_dly : rd_dly;
          if (req_cmd != CACHE::FLUSH && !cmem.exists(req_addr[63:3])) chk("req_addr_mapped", req_addr, 64'h1000);
        end
        if (active) begin
          if (cnt == 0) begin
            respcyc = 1'b1;
            resp_data = cmem.exists(s_addr[63:3]) ? cmem[s_addr[63:3]] : 64'd0;
          end else cnt--;
        end
      end
    end
  end
  task automatic do_op(input logic [1:0] k, input logic [1:0] s, input logic sg, input logic [63:0] a,
                       input logic [63:0] wd, input int rd, input int wr, input bit ghost);
    exp_t e;
    logic [63:0] b, v;
    int n, nd, t;
    bit m;
    n = 1 << s;
    m = (a % n) != 0;
    b = TRAP ? a : a - (a % n);
    e.data = '0; e.mis = 1'b0; e.lat = 0;
    if (TRAP && m) begin
      e.mis = 1'b1;
      e.lat = 1;
    end else if (k == 2'd0) begin
      v = '0;
      for (int i = 0; i < n; i++) v |= 64'(ref_mem[b + 64'(i)]) << (8 * i);
      if (sg && n < 8 && v[8 * n - 1]) v |= ~64'd0 << (8 * n);
      e.data = v;
      e.lat = rd + 2;
    end else if (k == 2'd1) begin
      if (!ghost) for (int i = 0; i < n; i++) ref_mem[b + 64'(i)] = 8'(wd >> (8 * i));
      e.lat = n == 8 ? wr + 2 : rd + wr + 3;
    end else begin
      if (!ghost) fl_q.push_back(b);
      e.lat = rd + 2;
    end
    rd_dly = rd; wr_dly = wr;
    t = 0;
    while (!op_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!op_ready) chk("op_ready_timeout", 64'd0, 64'd1);
    if (!ghost) exp_q.push_back(e);
    nd = n_done;
    op_valid = 1'b1; op_kind = k; op_size = s; op_signed = sg; op_addr = a; op_wdata = wd;
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (!ghost) begin
      t = 0;
      while (n_done == nd && t < 200) begin @(posedge clk); #1; t++; end
      if (n_done == nd) chk("done_timeout", 64'd0, 64'd1);
    end
  endtask
  initial begin
    logic [63:0] v, a;
    for (int j = 0; j < 8; j++) begin
      v = j == 0 ? 64'h8877665544332211 : {$urandom, $urandom};
      cmem[61'(64'h1000 >> 3) + 61'(j)] = v;
      for (int i = 0; i < 8; i++) ref_mem[64'h1000 + 64'(8 * j + i)] = 8'(v >> (8 * i));
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_op_ready", 64'(op_ready), 64'd1);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_done_data", done_data, 64'd0);
    chk("rst_done_mis", 64'(done_misaligned), 64'd0);
    chk("rst_req_cmd", 64'(req_cmd), 64'(CACHE::IDLE));
    chk("rst_req_addr", req_addr, 64'd0);
    chk("rst_req_data", req_data, 64'd0);
    do_op(2'd0, 2'd3, 1'b0, 64'h1000, 64'd0, 0, 0, 0);
    do_op(2'd0, 2'd0, 1'b1, 64'h1007, 64'd0, 0, 0, 0);
    do_op(2'd0, 2'd1, 1'b0, 64'h1002, 64'd0, 0, 0, 0);
    do_op(2'd1, 2'd0, 1'b0, 64'h1003, 64'hAB, 3, 0, 0);
    do_op(2'd0, 2'd3, 1'b0, 64'h1000, 64'd0, 1, 0, 0);
    do_op(2'd2, 2'd3, 1'b0, 64'h1000, 64'd0, 5, 0, 0);
    do_op(2'd0, 2'd2, 1'b0, 64'h1002, 64'd0, 0, 0, 0);
    do_op(2'd1, 2'd3, 1'b0, 64'h1008, 64'hDEAD_BEEF_0123_4567, 0, 20, 1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req_cmd", 64'(req_cmd), 64'(CACHE::IDLE));
    chk("async_rst_op_ready", 64'(op_ready), 64'd1);
    chk("async_rst_done_valid", 64'(done_valid), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    do_op(2'd0, 2'd3, 1'b0, 64'h1008, 64'd0, 0, 0, 0);
    for (int r = 0; r < 150; r++) begin
      a = 64'h1000 + 64'($urandom_range(0, 63));
      do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom), a, {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 2), 0);
    end
    repeat (4) @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      v = '0;
      for (int i = 0; i < 8; i++) v |= 64'(ref_mem[64'h1000 + 64'(8 * j + i)]) << (8 * i);
      chk("final_mem", cmem[61'(64'h1000 >> 3) + 61'(j)], v);
    end
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("fl_q_drained", 64'(fl_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
